// File: rtl/menu_arduino_tx.sv
// Serial status transmitter from the menu block to the Arduino display controller.
// Sends one 8N1 byte {P, menu_sel, value} whenever the selection changes or a resend is requested.
module menu_arduino_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600,
  parameter int VAL_W    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       menu_sel,
  input  logic [VAL_W-1:0] value,
  input  logic             resend,
  output logic             tx,
  output logic             busy,
  output logic             sent
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic             resend_pend, resend_pend_nxt;
  logic [6:0]       last_sent;
  logic [6:0]       cur;
  logic [3:0]       val_ext;
  logic [7:0]       shift;
  logic             launch;
  logic             bit_done;

  // Parity bit on top makes the total number of ones in the byte even.
  function automatic logic [7:0] status_byte(input logic [6:0] payload);
    return {^payload, payload};
  endfunction

  always_comb begin
    val_ext = '0;
    val_ext[VAL_W-1:0] = value;
  end

  assign cur      = {menu_sel, val_ext};
  assign launch   = (state == IDLE) && ((cur != last_sent) || resend_pend || resend);
  assign bit_done = (cnt == CNT_LAST);

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = bit_done ? '0 : cnt + 1'b1;
    bit_idx_nxt     = bit_idx;
    resend_pend_nxt = resend_pend | resend;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (launch) begin
          state_nxt       = START;
          resend_pend_nxt = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_idx_nxt = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      resend_pend <= 1'b1;
      last_sent   <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      resend_pend <= resend_pend_nxt;
      if (launch) last_sent <= cur;
    end
  end

  // Frame payload is held only while busy, so it needs no reset.
  always_ff @(posedge clock) begin
    if (launch) shift <= status_byte(cur);
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift[bit_idx];
      default: tx = 1'b1;
    endcase
  end

  assign busy = (state != IDLE);
  assign sent = (state == STOP) && bit_done;

endmodule

// File: tb/tb_menu_arduino_tx.sv
// Directed bench for menu_arduino_tx at DIV=16: frame contents, timing, coalescing, resend and reset.
module tb_menu_arduino_tx;

  logic       clock;
  logic       reset;
  logic [2:0] menu_sel;
  logic [3:0] value;
  logic       resend;
  logic       tx;
  logic       busy;
  logic       sent;

  int total = 0;
  int bad   = 0;
  int lat;

  menu_arduino_tx #(
    .CLK_FREQ(16),
    .BAUD    (1),
    .VAL_W   (4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .menu_sel(menu_sel),
    .value   (value),
    .resend  (resend),
    .tx      (tx),
    .busy    (busy),
    .sent    (sent)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits for the start bit, then checks every bit mid-cell, the sent pulse and the return to idle.
  task automatic expect_frame(input string tag, input logic [7:0] b, input int max_wait,
                              output int lat_o);
    logic [9:0] bits;
    int n;
    bits = {1'b1, b, 1'b0};
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (tx !== 1'b0 && n < max_wait);
    lat_o = n;
    chk($sformatf("%s_start", tag), 32'(tx), 32'(0));
    if (tx !== 1'b0) return;
    chk($sformatf("%s_busy", tag), 32'(busy), 32'(1));
    repeat (8) @(negedge clock);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) repeat (16) @(negedge clock);
      chk($sformatf("%s_bit%0d", tag, k), 32'(tx), 32'(bits[k]));
    end
    repeat (6) @(negedge clock);
    chk($sformatf("%s_sent_early", tag), 32'(sent), 32'(0));
    @(negedge clock);
    chk($sformatf("%s_sent", tag), 32'(sent), 32'(1));
    chk($sformatf("%s_busy_stop", tag), 32'(busy), 32'(1));
    @(negedge clock);
    chk($sformatf("%s_idle_busy", tag), 32'(busy), 32'(0));
    chk($sformatf("%s_idle_sent", tag), 32'(sent), 32'(0));
    chk($sformatf("%s_idle_tx", tag), 32'(tx), 32'(1));
  endtask

  initial begin
    reset    = 1'b0;
    menu_sel = 3'd0;
    value    = 4'd0;
    resend   = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_tx", 32'(tx), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_sent", 32'(sent), 32'(0));

    // First frame after reset reflects current inputs
    reset = 1'b1;
    expect_frame("f00", 8'h00, 40, lat);
    chk("f00_lat", 32'(lat), 32'(1));
    repeat (20) @(negedge clock);
    chk("f00_quiet_busy", 32'(busy), 32'(0));
    chk("f00_quiet_tx", 32'(tx), 32'(1));

    // Change to sel=2,value=5; coalesce 6 and 7 during the frame
    menu_sel = 3'd2;
    value    = 4'd5;
    fork
      expect_frame("fA5", 8'hA5, 40, lat);
      begin
        repeat (40) @(negedge clock);
        value = 4'd6;
        repeat (40) @(negedge clock);
        value = 4'd7;
      end
    join
    chk("fA5_lat", 32'(lat), 32'(1));
    expect_frame("f27", 8'h27, 40, lat);
    chk("f27_gap", 32'(lat), 32'(1));
    repeat (30) @(negedge clock);
    chk("f27_quiet_busy", 32'(busy), 32'(0));

    // Resend in idle, then two resends while busy
    resend = 1'b1;
    fork
      expect_frame("rs1", 8'h27, 40, lat);
      begin
        @(negedge clock);
        resend = 1'b0;
        repeat (30) @(negedge clock);
        resend = 1'b1;
        @(negedge clock);
        resend = 1'b0;
        repeat (50) @(negedge clock);
        resend = 1'b1;
        @(negedge clock);
        resend = 1'b0;
      end
    join
    chk("rs1_lat", 32'(lat), 32'(1));
    expect_frame("rs2", 8'h27, 40, lat);
    chk("rs2_gap", 32'(lat), 32'(1));
    repeat (30) @(negedge clock);
    chk("rs2_quiet_busy", 32'(busy), 32'(0));

    // Change then revert during DATA: no follow-up frame
    menu_sel = 3'd5;
    value    = 4'd3;
    fork
      expect_frame("f53", 8'h53, 40, lat);
      begin
        repeat (40) @(negedge clock);
        value = 4'd9;
        repeat (60) @(negedge clock);
        value = 4'd3;
      end
    join
    chk("f53_lat", 32'(lat), 32'(1));
    repeat (40) @(negedge clock);
    chk("f53_nofollow_busy", 32'(busy), 32'(0));
    chk("f53_nofollow_tx", 32'(tx), 32'(1));

    // Reset during DATA bit 3 of byte 0x14
    menu_sel = 3'd1;
    value    = 4'd4;
    @(negedge clock);
    chk("r_launch", 32'(tx), 32'(0));
    repeat (70) @(negedge clock);
    chk("r_bit3", 32'(tx), 32'(0));
    #2 reset = 1'b0;
    #1;
    chk("r_async_tx", 32'(tx), 32'(1));
    chk("r_async_busy", 32'(busy), 32'(0));
    chk("r_async_sent", 32'(sent), 32'(0));
    repeat (3) @(negedge clock);
    reset = 1'b1;
    expect_frame("f14", 8'h14, 40, lat);
    chk("f14_lat", 32'(lat), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
